// File: rtl/rsa_avm_pkg.sv
// Shared types and default UART register map for the RSA Avalon-MM stream controller.
package rsa_avm_pkg;

  typedef enum logic [2:0] {
    S_KEY_N = 3'd0,
    S_KEY_E = 3'd1,
    S_DATA  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_SEND  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_POLL = 2'd1,
    PH_RX   = 2'd2,
    PH_TX   = 2'd3
  } phase_e;

  localparam int unsigned DEF_RX_BASE     = 32'd0;
  localparam int unsigned DEF_TX_BASE     = 32'd4;
  localparam int unsigned DEF_STATUS_BASE = 32'd8;
  localparam int unsigned DEF_TX_OK_BIT   = 32'd6;
  localparam int unsigned DEF_RX_OK_BIT   = 32'd7;

  // Receive phases run n, then e, then the data block, then hand off to the core.
  function automatic state_e next_rx_state(input state_e s);
    case (s)
      S_KEY_N: next_rx_state = S_KEY_E;
      S_KEY_E: next_rx_state = S_DATA;
      S_DATA:  next_rx_state = S_START;
      default: next_rx_state = S_KEY_N;
    endcase
  endfunction

endpackage

// File: rtl/avm_uart_byte_port.sv
// Byte-level UART access over Avalon-MM: polls the status register, then performs
// one RX read or one TX write; strobes are registered and held through waitrequest.
module avm_uart_byte_port
  import rsa_avm_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32'd5,
  parameter int unsigned RX_BASE     = DEF_RX_BASE,
  parameter int unsigned TX_BASE     = DEF_TX_BASE,
  parameter int unsigned STATUS_BASE = DEF_STATUS_BASE,
  parameter int unsigned TX_OK_BIT   = DEF_TX_OK_BIT,
  parameter int unsigned RX_OK_BIT   = DEF_RX_OK_BIT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_rx_i,
  input  logic              req_tx_i,
  input  logic [7:0]        tx_byte_i,
  output logic              rx_valid_o,
  output logic [7:0]        rx_byte_o,
  output logic              tx_done_o,
  output logic [ADDR_W-1:0] avm_address_o,
  output logic              avm_read_o,
  input  logic [31:0]       avm_readdata_i,
  output logic              avm_write_o,
  output logic [31:0]       avm_writedata_o,
  input  logic              avm_waitrequest_i
);

  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(STATUS_BASE);
  localparam logic [ADDR_W-1:0] RX_ADDR     = ADDR_W'(RX_BASE);
  localparam logic [ADDR_W-1:0] TX_ADDR     = ADDR_W'(TX_BASE);

  phase_e            phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_s;
  logic              req_any_s;
  logic              unused_rd_s;

  assign done_s      = (read_q | write_q) & ~avm_waitrequest_i;
  assign req_any_s   = req_rx_i | req_tx_i;
  assign rx_valid_o  = (phase_q == PH_RX) & done_s;
  assign tx_done_o   = (phase_q == PH_TX) & done_s;
  assign rx_byte_o   = avm_readdata_i[7:0];
  assign unused_rd_s = ^avm_readdata_i;

  assign avm_address_o   = addr_q;
  assign avm_read_o      = read_q;
  assign avm_write_o     = write_q;
  assign avm_writedata_o = wdata_q;

  // Bus strobe and phase registers; reset leaves a status poll in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= PH_POLL;
      addr_q  <= STATUS_ADDR;
      read_q  <= 1'b1;
      write_q <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      phase_q <= phase_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  // Next access selection; nothing moves until the current access completes.
  always_comb begin
    phase_d = phase_q;
    addr_d  = addr_q;
    read_d  = read_q;
    write_d = write_q;
    wdata_d = wdata_q;
    case (phase_q)
      PH_IDLE: begin
        if (req_any_s) begin
          phase_d = PH_POLL;
          addr_d  = STATUS_ADDR;
          read_d  = 1'b1;
          write_d = 1'b0;
        end else begin
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      PH_POLL: begin
        if (done_s) begin
          if (req_rx_i && avm_readdata_i[RX_OK_BIT]) begin
            phase_d = PH_RX;
            addr_d  = RX_ADDR;
          end else if (req_tx_i && avm_readdata_i[TX_OK_BIT]) begin
            phase_d = PH_TX;
            addr_d  = TX_ADDR;
            read_d  = 1'b0;
            write_d = 1'b1;
            wdata_d = {24'd0, tx_byte_i};
          end else if (req_any_s) begin
            phase_d = PH_POLL;
          end else begin
            phase_d = PH_IDLE;
            read_d  = 1'b0;
          end
        end else begin
          phase_d = PH_POLL;
        end
      end
      PH_RX, PH_TX: begin
        if (done_s) begin
          addr_d  = STATUS_ADDR;
          write_d = 1'b0;
          if (req_any_s) begin
            phase_d = PH_POLL;
            read_d  = 1'b1;
          end else begin
            phase_d = PH_IDLE;
            read_d  = 1'b0;
          end
        end else begin
          phase_d = phase_q;
        end
      end
      default: begin
        phase_d = PH_POLL;
        addr_d  = STATUS_ADDR;
        read_d  = 1'b1;
        write_d = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rsa_avm_stream_ctrl.sv
// RSA stream controller: loads n and e over the UART, then per block collects the
// ciphertext, runs the external modexp core and returns all but the MSB result byte.
module rsa_avm_stream_ctrl
  import rsa_avm_pkg::*;
#(
  parameter int unsigned KEY_W       = 32'd256,
  parameter int unsigned ADDR_W      = 32'd5,
  parameter int unsigned RX_BASE     = DEF_RX_BASE,
  parameter int unsigned TX_BASE     = DEF_TX_BASE,
  parameter int unsigned STATUS_BASE = DEF_STATUS_BASE,
  parameter int unsigned TX_OK_BIT   = DEF_TX_OK_BIT,
  parameter int unsigned RX_OK_BIT   = DEF_RX_OK_BIT
) (
  input  logic              avm_clk,
  input  logic              avm_rst_n,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic              i_rekey,
  output logic              o_core_start,
  output logic [KEY_W-1:0]  o_core_a,
  output logic [KEY_W-1:0]  o_core_e,
  output logic [KEY_W-1:0]  o_core_n,
  input  logic [KEY_W-1:0]  i_core_result,
  input  logic              i_core_finished,
  output logic [15:0]       o_blocks_done
);

  localparam int unsigned BYTES = KEY_W / 32'd8;
  localparam int unsigned CNT_W = $clog2(BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_SEND = CNT_W'(BYTES - 32'd2);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] n_q, n_d, e_q, e_d, a_q, a_d, res_q, res_d;
  logic             rekey_q, rekey_d;
  logic             start_q, start_d;
  logic [15:0]      blocks_q, blocks_d;
  logic             rx_valid_s, tx_done_s, req_rx_s, req_tx_s;
  logic [7:0]       rx_byte_s, tx_byte_s;

  // Requests follow the next state so the port never issues a stray access on a hand-off.
  assign req_rx_s  = (state_d == S_KEY_N) | (state_d == S_KEY_E) | (state_d == S_DATA);
  assign req_tx_s  = (state_d == S_SEND);
  assign tx_byte_s = res_q[{cnt_q, 3'b000} +: 8];

  avm_uart_byte_port #(
    .ADDR_W      (ADDR_W),
    .RX_BASE     (RX_BASE),
    .TX_BASE     (TX_BASE),
    .STATUS_BASE (STATUS_BASE),
    .TX_OK_BIT   (TX_OK_BIT),
    .RX_OK_BIT   (RX_OK_BIT)
  ) u_port (
    .clk_i             (avm_clk),
    .rst_ni            (avm_rst_n),
    .req_rx_i          (req_rx_s),
    .req_tx_i          (req_tx_s),
    .tx_byte_i         (tx_byte_s),
    .rx_valid_o        (rx_valid_s),
    .rx_byte_o         (rx_byte_s),
    .tx_done_o         (tx_done_s),
    .avm_address_o     (avm_address),
    .avm_read_o        (avm_read),
    .avm_readdata_i    (avm_readdata),
    .avm_write_o       (avm_write),
    .avm_writedata_o   (avm_writedata),
    .avm_waitrequest_i (avm_waitrequest)
  );

  assign o_core_start  = start_q;
  assign o_core_n      = n_q;
  assign o_core_e      = e_q;
  assign o_core_a      = a_q;
  assign o_blocks_done = blocks_q;

  // Controller state, operand shift registers and counters.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      state_q  <= S_KEY_N;
      cnt_q    <= CNT_LAST;
      n_q      <= '0;
      e_q      <= '0;
      a_q      <= '0;
      res_q    <= '0;
      rekey_q  <= 1'b0;
      start_q  <= 1'b0;
      blocks_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      e_q      <= e_d;
      a_q      <= a_d;
      res_q    <= res_d;
      rekey_q  <= rekey_d;
      start_q  <= start_d;
      blocks_q <= blocks_d;
    end
  end

  // Next-state logic: byte collection, core hand-off and result return.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    e_d      = e_q;
    a_d      = a_q;
    res_d    = res_q;
    blocks_d = blocks_q;
    rekey_d  = rekey_q | i_rekey;
    start_d  = 1'b0;
    case (state_q)
      S_KEY_N, S_KEY_E, S_DATA: begin
        if (rx_valid_s) begin
          case (state_q)
            S_KEY_N: n_d = {n_q[KEY_W-9:0], rx_byte_s};
            S_KEY_E: e_d = {e_q[KEY_W-9:0], rx_byte_s};
            default: a_d = {a_q[KEY_W-9:0], rx_byte_s};
          endcase
          if (cnt_q == CNT_ZERO) begin
            cnt_d   = CNT_LAST;
            state_d = next_rx_state(state_q);
            start_d = (state_q == S_DATA);
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (i_core_finished) begin
          res_d   = i_core_result;
          cnt_d   = CNT_SEND;
          state_d = S_SEND;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_SEND: begin
        if (tx_done_s) begin
          if (cnt_q == CNT_ZERO) begin
            blocks_d = blocks_q + 16'd1;
            cnt_d    = CNT_LAST;
            if (rekey_d) begin
              state_d = S_KEY_N;
              rekey_d = 1'b0;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        state_d = S_KEY_N;
        cnt_d   = CNT_LAST;
      end
    endcase
  end

endmodule

// File: tb/tb_rsa_avm_stream_ctrl.sv
// Randomized bench: a UART slave model and a modexp core model check the controller
// against the byte stream and block/key sequence the bench itself builds.
module tb_rsa_avm_stream_ctrl;

  localparam int KW = 32;
  localparam int NB = KW / 8;
  localparam logic [4:0] A_RX = 5'd0;
  localparam logic [4:0] A_TX = 5'd4;
  localparam logic [4:0] A_ST = 5'd8;

  typedef struct {
    logic [KW-1:0] n;
    logic [KW-1:0] e;
    logic [KW-1:0] a;
  } blk_t;

  logic          avm_clk, avm_rst_n;
  logic [4:0]    avm_address;
  logic          avm_read, avm_write, avm_waitrequest;
  logic [31:0]   avm_readdata, avm_writedata;
  logic          i_rekey, o_core_start, i_core_finished;
  logic [KW-1:0] o_core_a, o_core_e, o_core_n, i_core_result;
  logic [15:0]   o_blocks_done;

  rsa_avm_stream_ctrl #(.KEY_W(KW)) dut (
    .avm_clk(avm_clk), .avm_rst_n(avm_rst_n),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .i_rekey(i_rekey), .o_core_start(o_core_start), .o_core_a(o_core_a),
    .o_core_e(o_core_e), .o_core_n(o_core_n), .i_core_result(i_core_result),
    .i_core_finished(i_core_finished), .o_blocks_done(o_blocks_done)
  );

  initial avm_clk = 1'b0;
  always #5 avm_clk = ~avm_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]    rx_q[$];
  logic [7:0]    tx_exp_q[$];
  blk_t          blk_q[$];
  logic [KW-1:0] res_force_q[$];
  logic [KW-1:0] cur_n, cur_e;

  int   rx_reads, tx_writes, starts;
  int   stall_len, stall_cnt, nok_left, rekey_at, core_delay;
  bit   rand_status, core_busy, rekey_arm, prev_valid, prev_stall, prev_start;
  logic [38:0]   prev_bus;
  logic [KW-1:0] core_res;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic feed_word(input logic [KW-1:0] v);
    for (int i = NB - 1; i >= 0; i--) rx_q.push_back(v[8*i +: 8]);
  endtask

  task automatic feed_key(input logic [KW-1:0] n, input logic [KW-1:0] e);
    cur_n = n;
    cur_e = e;
    feed_word(n);
    feed_word(e);
  endtask

  task automatic feed_block(input logic [KW-1:0] a);
    blk_t b;
    b.n = cur_n;
    b.e = cur_e;
    b.a = a;
    blk_q.push_back(b);
    feed_word(a);
  endtask

  task automatic wait_blocks(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge avm_clk);
      if (o_blocks_done == 16'(target)) break;
    end
    check_eq("blocks_done", 64'(o_blocks_done), 64'(target));
  endtask

  // UART slave and modexp core models, evaluated between clock edges.
  always @(negedge avm_clk) begin
    logic [31:0] rd;
    blk_t        b;
    if (!avm_rst_n) begin
      avm_waitrequest = 1'b0;
      stall_cnt       = 0;
      core_busy       = 1'b0;
      rekey_arm       = 1'b0;
      i_core_finished = 1'b0;
      i_rekey         = 1'b0;
      prev_valid      = 1'b0;
      prev_start      = 1'b0;
    end else begin
      i_core_finished = 1'b0;
      i_rekey         = 1'b0;
      if (prev_valid && prev_stall)
        check_eq("bus_hold", 64'({avm_address, avm_read, avm_write, avm_writedata}), 64'(prev_bus));
      if (avm_read || avm_write) begin
        if (stall_cnt < stall_len) begin
          avm_waitrequest = 1'b1;
          avm_readdata    = $urandom;
          stall_cnt++;
        end else begin
          avm_waitrequest = 1'b0;
          stall_cnt       = 0;
          rd              = $urandom;
          if (avm_read && avm_address == A_ST) begin
            rd[7] = (rx_q.size() > 0) && (nok_left == 0) && (rand_status ? ($urandom_range(1) == 1) : 1'b1);
            rd[6] = rand_status ? ($urandom_range(1) == 1) : 1'b1;
            if (nok_left > 0) nok_left--;
          end else if (avm_read && avm_address == A_RX) begin
            rx_reads++;
            if (rx_q.size() > 0) rd[7:0] = rx_q.pop_front();
            else check_eq("rx_avail", 64'(rx_q.size()), 64'd1);
          end else if (avm_write) begin
            tx_writes++;
            check_eq("tx_addr", 64'(avm_address), 64'(A_TX));
            if (tx_exp_q.size() > 0) check_eq("tx_data", 64'(avm_writedata), 64'({24'd0, tx_exp_q.pop_front()}));
            else check_eq("tx_extra", 64'(tx_exp_q.size()), 64'd1);
          end else begin
            check_eq("rd_addr", 64'(avm_address), 64'(A_ST));
          end
          avm_readdata = rd;
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
      prev_bus   = {avm_address, avm_read, avm_write, avm_writedata};
      prev_stall = (avm_read || avm_write) && avm_waitrequest;
      prev_valid = 1'b1;

      if (rekey_arm) begin
        i_rekey   = 1'b1;
        rekey_arm = 1'b0;
      end
      if (o_core_start) begin
        starts++;
        check_eq("start_width", 64'(prev_start), 64'd0);
        if (blk_q.size() > 0) begin
          b = blk_q.pop_front();
          check_eq("core_n", 64'(o_core_n), 64'(b.n));
          check_eq("core_e", 64'(o_core_e), 64'(b.e));
          check_eq("core_a", 64'(o_core_a), 64'(b.a));
        end else begin
          check_eq("blk_avail", 64'(blk_q.size()), 64'd1);
        end
        core_res   = (res_force_q.size() > 0) ? res_force_q.pop_front() : KW'($urandom);
        for (int i = NB - 2; i >= 0; i--) tx_exp_q.push_back(core_res[8*i +: 8]);
        core_busy  = 1'b1;
        core_delay = 3 + $urandom_range(4);
        if (starts == rekey_at) rekey_arm = 1'b1;
      end else if (core_busy) begin
        if (core_delay == 0) begin
          i_core_finished = 1'b1;
          i_core_result   = core_res;
          core_busy       = 1'b0;
        end else begin
          core_delay--;
        end
      end
      prev_start = o_core_start;
    end
  end

  initial begin
    int base;
    avm_rst_n     = 1'b0;
    avm_readdata  = 32'd0;
    i_core_result = '0;
    stall_len     = 0;
    nok_left      = 0;
    rand_status   = 1'b0;
    rekey_at      = 0;
    rx_reads      = 0;
    tx_writes     = 0;
    starts        = 0;
    repeat (3) @(posedge avm_clk);
    #1;
    check_eq("rst_addr", 64'(avm_address), 64'(A_ST));
    check_eq("rst_strobes", 64'({avm_read, avm_write}), 64'(2'b10));
    check_eq("rst_wdata", 64'(avm_writedata), 64'd0);
    check_eq("rst_start_blocks", 64'({o_core_start, o_blocks_done}), 64'd0);
    check_eq("rst_key", 64'({o_core_n, o_core_e, o_core_a}), 64'd0);

    // Directed first block with the example key and ciphertext.
    feed_key(32'h00000CA3, 32'h00000005);
    feed_block(32'h00000041);
    res_force_q.push_back(32'h00ABCDEF);
    @(posedge avm_clk); #2;
    avm_rst_n = 1'b1;
    wait_blocks(1, 2000);
    check_eq("rx_reads_b1", 64'(rx_reads), 64'd12);
    check_eq("starts_b1", 64'(starts), 64'd1);
    check_eq("tx_writes_b1", 64'(tx_writes), 64'd3);
    check_eq("n_b1", 64'(o_core_n), 64'h0CA3);
    check_eq("e_b1", 64'(o_core_e), 64'h5);
    check_eq("a_b1", 64'(o_core_a), 64'h41);
    repeat (20) @(negedge avm_clk);
    check_eq("idle_poll", 64'({avm_address, avm_read, avm_write}), 64'({A_ST, 2'b10}));
    check_eq("idle_rx_reads", 64'(rx_reads), 64'd12);

    // Stalled bus, withheld RX_OK, re-key during block 2.
    stall_len   = 3;
    nok_left    = 5;
    rand_status = 1'b1;
    rekey_at    = 2;
    feed_block(KW'($urandom));
    feed_key(KW'($urandom), KW'($urandom));
    feed_block(KW'($urandom));
    wait_blocks(3, 20000);
    check_eq("rx_reads_b3", 64'(rx_reads), 64'd28);
    check_eq("starts_b3", 64'(starts), 64'd3);
    check_eq("n_rekeyed", 64'(o_core_n), 64'(cur_n));

    // Random blocks under random stall lengths.
    for (int k = 0; k < 4; k++) begin
      stall_len = $urandom_range(2);
      feed_block(KW'($urandom));
      wait_blocks(4 + k, 20000);
    end
    check_eq("tx_writes_b7", 64'(tx_writes), 64'(7 * (NB - 1)));

    // Reset after the first byte of a block has been written.
    stall_len   = 0;
    rand_status = 1'b0;
    base        = tx_writes;
    feed_block(KW'($urandom));
    for (int i = 0; i < 5000; i++) begin
      @(negedge avm_clk);
      if (tx_writes == base + 1) break;
    end
    check_eq("first_tx_seen", 64'(tx_writes), 64'(base + 1));
    @(posedge avm_clk); #2;
    avm_rst_n = 1'b0;
    #1;
    check_eq("mid_rst_bus", 64'({avm_address, avm_read, avm_write}), 64'({A_ST, 2'b10}));
    check_eq("mid_rst_blocks", 64'(o_blocks_done), 64'd0);
    tx_exp_q.delete();
    blk_q.delete();
    rx_q.delete();
    res_force_q.delete();
    rx_reads = 0;
    starts   = 0;
    rekey_at = 0;
    repeat (3) @(posedge avm_clk);
    #2;
    feed_key(KW'($urandom), KW'($urandom));
    feed_block(KW'($urandom));
    avm_rst_n = 1'b1;
    wait_blocks(1, 5000);
    check_eq("rx_reads_restart", 64'(rx_reads), 64'd12);
    check_eq("starts_restart", 64'(starts), 64'd1);
    check_eq("tx_left", 64'(tx_exp_q.size()), 64'd0);
    check_eq("rx_left", 64'(rx_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
